// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: n/a (types, constants and an elaboration-time divisor function only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;

    // Baud select encoding as seen in the CTRL.BAUD register field.
    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_38400  = 2'd1,
        BAUD_115200 = 2'd2,
        BAUD_RSVD   = 2'd3
    } ctrl_baud_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Clocks per oversample tick, rounded to nearest. Reserved select falls back to 9600.
    function automatic int baud_div(input int clk_freq, input ctrl_baud_t sel);
        int baud;
        case (sel)
            BAUD_38400:  baud = 38400;
            BAUD_115200: baud = 115200;
            default:     baud = 9600;
        endcase
        return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: pop_dat always presents the head entry.
// Latency: a push is visible at the head the cycle after it is accepted; pop advances next cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
//   clk, rst       : clock, synchronous active-high reset
//   push, push_dat : write request and data
//   pop, pop_dat   : read request and head data
//   full, empty    : occupancy flags
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = pop && !empty;
    // A pop on a full FIFO frees the slot the push is about to use.
    assign wr_ok   = push && (!full || rd_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF pin synchroniser, 16x oversampled frame FSM, show-ahead byte FIFO with error flags.
// Latency: 2 clk pin-to-start-detect; byte at FIFO head and rx_irq pulse one clk after the mid-stop sample.
// Backpressure: none toward the line; a completed byte arriving on a full FIFO is dropped and rx_ovf pulses.
//   rxd            : async serial input (idle 1)       ctrl_baud : 0=9600 1=38400 2=115200 3=9600
//   rx_en          : receive enable                    rx_pop    : pop FIFO head
//   rx_data/ferr/perr : head entry, zero when empty    rx_empty  : FIFO empty
//   rx_irq / rx_ovf   : push / drop pulses             rx_busy   : frame in progress
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 18_432_000,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] ctrl_baud,
    input  logic       rx_en,
    input  logic       rx_pop,
    output logic [7:0] rx_data,
    output logic       rx_ferr,
    output logic       rx_perr,
    output logic       rx_empty,
    output logic       rx_irq,
    output logic       rx_ovf,
    output logic       rx_busy
);

    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(baud_div(CLK_FREQ, BAUD_9600));
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(baud_div(CLK_FREQ, BAUD_38400));
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(baud_div(CLK_FREQ, BAUD_115200));

    rx_state_t        state, state_nxt;
    logic             sync1, rxd_s, rxd_prev;
    logic [DIV_W-1:0] sel_div, div_q, div_cnt;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_q;
    logic             tick, sample, start_det, push;
    logic             irq_q, ovf_q;
    logic             fifo_full, fifo_empty;
    rx_entry_t        push_ent, head;

    always_comb begin
        case (ctrl_baud_t'(ctrl_baud))
            BAUD_38400:  sel_div = DIV_38400;
            BAUD_115200: sel_div = DIV_115200;
            default:     sel_div = DIV_9600;
        endcase
    end

    // Sample points: 8th tick for mid-start, then every 16th tick (mid-bit).
    assign tick   = (div_cnt == div_q - 1'b1);
    assign sample = tick && (tick_cnt == ((state == ST_START) ? 4'd7 : 4'd15));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync1    <= rxd;
            rxd_s    <= sync1;
            rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        push      = 1'b0;
        if (!rx_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rxd_prev && !rxd_s) begin
                        start_det = 1'b1;
                        state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    if (sample) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample && bit_cnt == 3'd7)
                        state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (sample) state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    if (sample) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= DIV_9600;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            irq_q <= push && (!fifo_full || rx_pop);
            ovf_q <= push && fifo_full && !rx_pop;
            if (start_det) begin
                // Divisor frozen for the whole frame.
                div_q    <= sel_div;
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != ST_IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= (state == ST_START && sample) ? 4'd0 : tick_cnt + 4'd1;
                if (sample && state == ST_DATA) begin
                    shift   <= {rxd_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (sample && state == ST_PARITY) par_q <= rxd_s;
            end
        end
    end

    assign push_ent.ferr = ~rxd_s;
    assign push_ent.perr = (PARITY_EN != 0) ? ((^shift) ^ par_q) : 1'b0;
    assign push_ent.data = shift;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (rx_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_empty = fifo_empty;
    assign rx_data  = fifo_empty ? 8'h00 : head.data;
    assign rx_ferr  = fifo_empty ? 1'b0  : head.ferr;
    assign rx_perr  = fifo_empty ? 1'b0  : head.perr;
    assign rx_irq   = irq_q;
    assign rx_ovf   = ovf_q;
    assign rx_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int B115 = 160;   // clocks per bit at 115200
    localparam int B9600 = 1920; // clocks per bit at 9600

    logic       clk = 1'b0;
    logic       rst, rxd, rx_en, rx_pop;
    logic [1:0] ctrl_baud;
    logic [7:0] rx_data;
    logic       rx_ferr, rx_perr, rx_empty, rx_irq, rx_ovf, rx_busy;

    int n_vec = 0;
    int n_err = 0;
    int irq_cnt = 0;
    int ovf_cnt = 0;
    int i0, o0;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ   (18_432_000),
        .FIFO_DEPTH (4),
        .PARITY_EN  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .ctrl_baud (ctrl_baud),
        .rx_en     (rx_en),
        .rx_pop    (rx_pop),
        .rx_data   (rx_data),
        .rx_ferr   (rx_ferr),
        .rx_perr   (rx_perr),
        .rx_empty  (rx_empty),
        .rx_irq    (rx_irq),
        .rx_ovf    (rx_ovf),
        .rx_busy   (rx_busy)
    );

    always @(negedge clk) begin
        if (rx_irq) irq_cnt++;
        if (rx_ovf) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(negedge clk);
        rxd = b;
        repeat (n - 1) @(negedge clk);
    endtask

    // start, 8 data LSB first, parity, stop, then one idle bit
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bclk);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
        drive_bit(par, bclk);
        drive_bit(stp, bclk);
        drive_bit(1'b1, bclk);
    endtask

    task automatic good_frame(input logic [7:0] d, input int bclk);
        send_frame(d, ^d, 1'b1, bclk);
    endtask

    task automatic pop;
        @(negedge clk);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; rx_en = 1'b1; rx_pop = 1'b0; ctrl_baud = 2'd2;
        repeat (3) @(negedge clk);
        chk("rst_empty", rx_empty, 1);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_perr", rx_perr, 0);
        chk("rst_irq", rx_irq, 0);
        chk("rst_ovf", rx_ovf, 0);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame at 115200
        i0 = irq_cnt;
        good_frame(8'hA5, B115);
        chk("a5_irq", irq_cnt - i0, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_ferr", rx_ferr, 0);
        chk("a5_perr", rx_perr, 0);
        chk("a5_empty", rx_empty, 0);
        pop();
        chk("a5_pop_empty", rx_empty, 1);
        chk("a5_pop_data", rx_data, 0);

        // Parity error, then framing error
        send_frame(8'h3C, 1'b1, 1'b1, B115);
        chk("perr_data", rx_data, 8'h3C);
        chk("perr_perr", rx_perr, 1);
        chk("perr_ferr", rx_ferr, 0);
        pop();
        send_frame(8'h3C, 1'b0, 1'b0, B115);
        chk("ferr_data", rx_data, 8'h3C);
        chk("ferr_ferr", rx_ferr, 1);
        chk("ferr_perr", rx_perr, 0);
        pop();
        chk("ferr_pop_empty", rx_empty, 1);

        // 60-clk low glitch
        i0 = irq_cnt;
        drive_bit(1'b0, 60);
        chk("glitch_busy_hi", rx_busy, 1);
        drive_bit(1'b1, 100);
        chk("glitch_busy_lo", rx_busy, 0);
        chk("glitch_no_irq", irq_cnt - i0, 0);
        chk("glitch_empty", rx_empty, 1);
        good_frame(8'h55, B115);
        chk("after_glitch_irq", irq_cnt - i0, 1);
        chk("after_glitch_data", rx_data, 8'h55);
        pop();

        // Overflow on depth-4 FIFO
        i0 = irq_cnt; o0 = ovf_cnt;
        for (int d = 1; d <= 5; d++) good_frame(8'(d), B115);
        chk("ovf_irq", irq_cnt - i0, 4);
        chk("ovf_ovf", ovf_cnt - o0, 1);
        chk("ovf_head", rx_data, 8'h01);
        // Pop lands on the stop-sample push cycle (1682 clk after the start edge)
        fork
            good_frame(8'h06, B115);
            begin
                repeat (1683) @(negedge clk);
                rx_pop = 1'b1;
                @(negedge clk);
                rx_pop = 1'b0;
            end
        join
        chk("full_pp_irq", irq_cnt - i0, 5);
        chk("full_pp_ovf", ovf_cnt - o0, 1);
        chk("full_pp_head2", rx_data, 8'h02);
        pop();
        chk("full_pp_head3", rx_data, 8'h03);
        pop();
        chk("full_pp_head4", rx_data, 8'h04);
        pop();
        chk("full_pp_head6", rx_data, 8'h06);
        chk("full_pp_not_empty", rx_empty, 0);
        pop();
        chk("drain_empty", rx_empty, 1);
        pop();
        chk("pop_empty_still", rx_empty, 1);
        chk("pop_empty_data", rx_data, 0);

        // rx_en dropped during data bit 3 at 9600
        ctrl_baud = 2'd0;
        i0 = irq_cnt; o0 = ovf_cnt;
        drive_bit(1'b0, B9600);
        drive_bit(1'b0, B9600);
        drive_bit(1'b1, B9600);
        drive_bit(1'b0, B9600);
        drive_bit(1'b1, B9600 / 2);
        rx_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("dis_busy", rx_busy, 0);
        rxd = 1'b1;
        repeat (B9600) @(negedge clk);
        rx_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("dis_no_irq", irq_cnt - i0, 0);
        chk("dis_no_ovf", ovf_cnt - o0, 0);
        chk("dis_empty", rx_empty, 1);
        good_frame(8'h7E, B9600);
        chk("7e_irq", irq_cnt - i0, 1);
        chk("7e_data", rx_data, 8'h7E);
        chk("7e_ferr", rx_ferr, 0);
        chk("7e_perr", rx_perr, 0);
        pop();

        // Reset mid-frame with two bytes queued
        ctrl_baud = 2'd2;
        good_frame(8'hAA, B115);
        good_frame(8'h0F, B115);
        chk("q2_head", rx_data, 8'hAA);
        drive_bit(1'b0, B115);
        drive_bit(1'b1, B115);
        chk("mid_busy", rx_busy, 1);
        rxd = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_empty", rx_empty, 1);
        chk("mrst_data", rx_data, 0);
        chk("mrst_busy", rx_busy, 0);
        chk("mrst_irq", rx_irq, 0);
        chk("mrst_ovf", rx_ovf, 0);
        chk("mrst_ferr", rx_ferr, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        i0 = irq_cnt;
        good_frame(8'hC3, B115);
        chk("c3_irq", irq_cnt - i0, 1);
        chk("c3_data", rx_data, 8'hC3);
        pop();
        chk("c3_empty", rx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
